// File: rtl/button_debouncer.sv
// Push-button synchroniser and bounce filter producing a clean, registered level.
// Optional BTN_ACTIVE_LOW_EN: inverts btn_in ahead of the synchroniser for pull-up buttons.
module button_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic btn_level,
  output logic bouncing
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   level_nxt;
  logic                   bouncing_nxt;
  logic                   btn_raw;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_q;

`ifdef BTN_ACTIVE_LOW_EN
  assign btn_raw = ~btn_in;
`else
  assign btn_raw = btn_in;
`endif

  // Synchroniser chain; reset value 0 means "released" in either polarity.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign sync_q = sync_ff[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE_LOW;
      cnt       <= '0;
      btn_level <= 1'b0;
      bouncing  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      btn_level <= level_nxt;
      bouncing  <= bouncing_nxt;
    end
  end

  // Qualification: a new level commits only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = btn_level;
    case (state)
      IDLE_LOW: begin
        if (sync_q) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = CNT_W'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
      WAIT_HIGH: begin
        if (!sync_q) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HIGH;
          level_nxt = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!sync_q) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = CNT_W'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
      WAIT_LOW: begin
        if (sync_q) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LOW;
          level_nxt = 1'b0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        cnt_nxt   = '0;
      end
    endcase
    bouncing_nxt = (state_nxt == WAIT_HIGH) || (state_nxt == WAIT_LOW);
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: run-length reference model, vector table, corner sequences.
module tb_button_debouncer;

  localparam int unsigned SYNC_STAGES     = 2;
  localparam int unsigned DEBOUNCE_CYCLES = 16;
`ifdef BTN_ACTIVE_LOW_EN
  localparam bit ACT_LOW = 1'b1;
`else
  localparam bit ACT_LOW = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic btn_in;
  logic btn_level;
  logic bouncing;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model in "pressed" terms: a delay line plus a run length of disagreeing samples.
  bit          m_sync[SYNC_STAGES];
  bit          m_level;
  int unsigned m_run;

  button_debouncer #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .bouncing  (bouncing)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          press;
    int unsigned cycles;
    bit          level;
    bit          bounce;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(SYNC_STAGES); i++) m_sync[i] = 1'b0;
    m_level = 1'b0;
    m_run   = 0;
  endtask

  task automatic model_edge(input bit press);
    bit old_q;
    old_q = m_sync[SYNC_STAGES-1];
    for (int i = int'(SYNC_STAGES) - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = press;
    if (old_q != m_level) begin
      m_run++;
      if (m_run == DEBOUNCE_CYCLES) begin
        m_level = ~m_level;
        m_run   = 0;
      end
    end else begin
      m_run = 0;
    end
  endtask

  // One clock with the button at 'press'; outputs compared 1 time unit after the edge.
  task automatic step(input bit press);
    btn_in = press ^ ACT_LOW;
    @(posedge clk);
    model_edge(press);
    #1;
    check("model_level", btn_level, m_level);
    check("model_bouncing", bouncing, m_run != 0);
  endtask

  initial begin
    int steps;
    bit done;

    reset_n = 1'b0;
    btn_in  = ACT_LOW;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_level", btn_level, 1'b0);
    check("reset_bouncing", bouncing, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Clean press: commit on the 18th edge, bouncing from edge 2 up to the commit.
    for (int e = 0; e < 18; e++) begin
      step(1'b1);
      check("press_level", btn_level, e >= 17);
      check("press_bouncing", bouncing, (e >= 2) && (e < 17));
    end

    // Segments applied back-to-back starting from a settled pressed state.
    vecs[0] = '{press: 1'b0, cycles: 5,  level: 1'b1, bounce: 1'b1};
    vecs[1] = '{press: 1'b1, cycles: 20, level: 1'b1, bounce: 1'b0};
    vecs[2] = '{press: 1'b0, cycles: 17, level: 1'b1, bounce: 1'b1};
    vecs[3] = '{press: 1'b0, cycles: 1,  level: 1'b0, bounce: 1'b0};
    vecs[4] = '{press: 1'b1, cycles: 15, level: 1'b0, bounce: 1'b1};
    vecs[5] = '{press: 1'b0, cycles: 20, level: 1'b0, bounce: 1'b0};
    vecs[6] = '{press: 1'b1, cycles: 16, level: 1'b0, bounce: 1'b1};
    for (int v = 0; v < 7; v++) begin
      repeat (vecs[v].cycles) step(vecs[v].press);
      check($sformatf("vec%0d_level", v), btn_level, vecs[v].level);
      check($sformatf("vec%0d_bouncing", v), bouncing, vecs[v].bounce);
    end
    // A 16-cycle pulse is just long enough to commit.
    repeat (2) step(1'b0);
    check("pulse16_level", btn_level, 1'b1);
    check("pulse16_bouncing", bouncing, 1'b0);
    repeat (20) step(1'b0);
    check("pulse16_release_level", btn_level, 1'b0);

    // Bounce rejection: 3-cycle toggling never commits; then 18 edges to press.
    for (int i = 0; i < 40; i++) step(((i / 3) % 2) == 0);
    check("toggle_level", btn_level, 1'b0);
    steps = 0;
    done  = 1'b0;
    while (!done && steps < 40) begin
      step(1'b1);
      steps++;
      if (btn_level) done = 1'b1;
    end
    check("toggle_rise_seen", done, 1'b1);
    check("toggle_latency_18", steps == 18, 1'b1);
    if (steps != 18) $display("FAIL toggle_latency: got %0d edges expected 18", steps);

    // Randomised run lengths around the threshold.
    for (int r = 0; r < 120; r++) begin
      bit          p;
      int unsigned len;
      p   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 24);
      repeat (len) step(p);
    end

    // Reset during WAIT_LOW with level high takes effect without a clock edge.
    steps = 0;
    while (!btn_level && steps < 40) begin
      step(1'b1);
      steps++;
    end
    check("pre_reset_level", btn_level, 1'b1);
    repeat (5) step(1'b0);
    check("pre_reset_bouncing", bouncing, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_level", btn_level, 1'b0);
    check("async_reset_bouncing", bouncing, 1'b0);
    model_reset();
    btn_in = ACT_LOW;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step(1'b0);
    check("post_reset_level", btn_level, 1'b0);
    repeat (18) step(1'b1);
    check("post_reset_press", btn_level, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Front-end conditioning stage for raw mechanical push-button inputs. It synchronises an asynchronous button signal into the `clk` domain and filters contact bounce with a per-edge stability counter. It presents a clean, glitch-free level to the downstream level-to-pulse converter. One instance is used per physical button; the output level feeds that converter's level input directly.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flop count, legal ≥2.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable samples required to commit a new level, legal ≥2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: derived, not overridden by instantiators.
- `clk` input 1: single system clock; all flops are rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `btn_in` input 1: raw button, asynchronous to `clk`.
- `btn_level` output 1: debounced level, registered.
- `bouncing` output 1: high while a candidate transition is being qualified.

## Operation
- Synchroniser: `SYNC_STAGES`-deep flop chain on `btn_in`; the last stage is `sync_q`, and only `sync_q` is used downstream.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW. 2-bit encoding.
- Counter `cnt`, `CNT_W` bits, unsigned.
- IDLE_LOW:
  - `sync_q`=1 → WAIT_HIGH, `cnt`←1.
  - Otherwise hold, `cnt`←0.
- WAIT_HIGH:
  - `sync_q`=0 → IDLE_LOW, `cnt`←0 (bounce rejected).
  - Else if `cnt`==DEBOUNCE_CYCLES-1 → IDLE_HIGH, `btn_level`←1, `cnt`←0.
  - Else `cnt`←`cnt`+1.
- IDLE_HIGH and WAIT_LOW mirror IDLE_LOW and WAIT_HIGH with polarity inverted; commit clears `btn_level`←0.
- `cnt` never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- `bouncing` = state ∈ {WAIT_HIGH, WAIT_LOW}. It is decoded from the state register, so it is glitch-free.
- `btn_level` changes only on a commit edge; it never changes in the IDLE states.
- Illegal or unreachable state code → IDLE_LOW next cycle, `cnt`←0. `btn_level` holds its value until the next legitimate commit.

## Timing
- Reset (`reset_n`=0, asynchronous): all sync flops 0, state IDLE_LOW, `cnt`=0, `btn_level`=0, `bouncing`=0.
- Reset deassertion is released synchronously by the integrating top level. The block adds no reset synchroniser.
- Press latency: `btn_in` rises before edge 0 and stays high. `btn_level` goes high after edge SYNC_STAGES+DEBOUNCE_CYCLES-1, i.e. on the 18th edge with defaults.
- Release latency is identical, in mirror.
- `bouncing` rises after edge SYNC_STAGES and falls on the same edge at which `btn_level` commits.
- A `sync_q` excursion lasting ≤DEBOUNCE_CYCLES-1 cycles is rejected: `btn_level` is unchanged and `bouncing` pulses for the excursion length.
- After a rejection, qualification restarts from `cnt`=1 on the next differing sample; partial counts are never retained.
- Reset asserted mid-WAIT: immediate return to reset values. `btn_level`=0 even if it was 1.
- No handshake exists. The downstream converter samples `btn_level` every cycle; its first pulse needs `btn_level` low for ≥1 cycle after reset, which this block guarantees.

## Configuration
- `BTN_ACTIVE_LOW_EN` defined: `btn_in` is inverted before the first synchroniser flop, for pull-up buttons where pressed is 0. All internal behaviour and `btn_level` polarity (1 = pressed) are unchanged.
- Sync flops still reset to 0, which means "released".
- Not defined: `btn_in` is used non-inverted, and 1 = pressed.

## Test plan
- Clean press: reset, then hold `btn_in`=1 from before edge 0 → `btn_level` is 0 through edge 16 and 1 after edge 17; `bouncing` is high from after edge 2 until the edge-17 commit.
- Bounce rejection: `btn_in` toggles 1/0 every 3 cycles for 40 cycles, then holds 1 → `btn_level` stays 0 during toggling and rises 18 edges after the final rising transition.
- Threshold glitch: `btn_in` high for exactly 15 cycles, then low → `btn_level` never rises and `bouncing` returns to 0; a 16-cycle high pulse → `btn_level` rises.
- Release: from `btn_level`=1, drive `btn_in`=0 → `btn_level` falls after 18 edges; a 5-cycle 0-glitch while high leaves `btn_level`=1.
- Reset mid-operation: assert `reset_n`=0 during WAIT_LOW with `btn_level`=1 → `btn_level`=0 and `bouncing`=0 immediately, without waiting for a clock edge.
- With `BTN_ACTIVE_LOW_EN`: hold `btn_in`=0 → `btn_level` rises after 18 edges; with `btn_in`=1 → `btn_level` stays 0.
